echo_pulse_gen_multi: RTL

- Parametrised multi-channel ultrasonic echo generator.
- On a trigger edge, each channel waits a programmable flight delay, then drives ECHO high for a programmable width.
- Used on the board to emulate sensor returns when exercising the ultrasonic ranging logic without real transducers.
- Successor to the single-channel, level-loaded echo counter. Adds a delay phase, edge-triggering, a prescaler, retrigger mode, and busy/done status.

---
 rtl/echo_pulse_gen_multi.sv | 131 +++++++++++++
 1 files changed

// File: rtl/echo_pulse_gen_multi.sv
// Multi-channel ultrasonic echo emulator: on a trigger edge each channel waits a
// programmable flight delay, then drives ECHO high for a programmable width.
//
// state   | meaning
// IDLE    | waiting for a rising edge on entrada
// DELAY   | counting down the latched flight delay
// PULSE   | ECHO high, counting down the latched echo width
module echo_pulse_gen_multi #(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 8,
    parameter int PRESCALE  = 1,
    parameter int RETRIGGER = 0
) (
    input  logic                      CLKOUT,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       entrada,
    input  logic [CHANNELS*WIDTH-1:0] retardo,
    input  logic [CHANNELS*WIDTH-1:0] cantidad,
    output logic [CHANNELS-1:0]       ECHO,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_PULSE} state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t           state;
        logic [WIDTH-1:0] dcnt;
        logic [WIDTH-1:0] wcnt;
        logic [PW-1:0]    pre;
        logic             prev;
        logic             echo_r;
        logic             busy_r;
        logic             done_r;
        logic [WIDTH-1:0] d_in;
        logic [WIDTH-1:0] w_in;
        logic             edge_det;
        logic             accept;
        logic             step;

        assign d_in     = retardo[i*WIDTH +: WIDTH];
        assign w_in     = cantidad[i*WIDTH +: WIDTH];
        assign edge_det = entrada[i] & ~prev;
        assign accept   = edge_det && ((state == S_IDLE) || (RETRIGGER != 0));
        assign step     = (pre == PRE_LAST);

        // Outputs are registered from the next state, so ECHO/busy/done line up
        // with the state they describe.
        always_ff @(posedge CLKOUT) begin
            if (reset) begin
                state  <= S_IDLE;
                dcnt   <= '0;
                wcnt   <= '0;
                pre    <= '0;
                prev   <= 1'b0;
                echo_r <= 1'b0;
                busy_r <= 1'b0;
                done_r <= 1'b0;
            end else begin
                prev   <= entrada[i];
                done_r <= 1'b0;
                if (accept) begin
                    dcnt <= d_in;
                    wcnt <= w_in;
                    pre  <= '0;
                    if (d_in != '0) begin
                        state  <= S_DELAY;
                        busy_r <= 1'b1;
                        echo_r <= 1'b0;
                    end else if (w_in != '0) begin
                        state  <= S_PULSE;
                        busy_r <= 1'b1;
                        echo_r <= 1'b1;
                    end else begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                        echo_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end else begin
                    case (state)
                        S_DELAY: begin
                            pre <= step ? '0 : pre + 1'b1;
                            if (step) begin
                                if (dcnt <= WIDTH'(1)) begin
                                    dcnt <= '0;
                                    if (wcnt != '0) begin
                                        state  <= S_PULSE;
                                        echo_r <= 1'b1;
                                    end else begin
                                        state  <= S_IDLE;
                                        busy_r <= 1'b0;
                                        done_r <= 1'b1;
                                    end
                                end else begin
                                    dcnt <= dcnt - 1'b1;
                                end
                            end
                        end
                        S_PULSE: begin
                            pre <= step ? '0 : pre + 1'b1;
                            if (step) begin
                                if (wcnt <= WIDTH'(1)) begin
                                    wcnt   <= '0;
                                    state  <= S_IDLE;
                                    echo_r <= 1'b0;
                                    busy_r <= 1'b0;
                                    done_r <= 1'b1;
                                end else begin
                                    wcnt <= wcnt - 1'b1;
                                end
                            end
                        end
                        default: begin
                            state <= S_IDLE;
                            pre   <= '0;
                        end
                    endcase
                end
            end
        end

        assign ECHO[i] = echo_r;
        assign busy[i] = busy_r;
        assign done[i] = done_r;
    end

endmodule
